// File: rtl/frame_loader.sv
// frame_loader
//   Write side of the shared image RAM. Accepts a byte stream of filtered
//   pixels over a valid/ready handshake and writes one complete image into
//   the slot selected when the load was started. The display path reads the
//   same RAM on its own port and is not involved here.
//
// Parameters
//   IMG_W   pixels per line (power of two, >= 2)
//   IMG_H   lines per image (power of two, >= 2)
//   ADDR_W  RAM address width, {slot, y, x}
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   start, slot         load request (IDLE only) and target slot
//   abort               cancel a load in progress, no done pulse
//   s_data/s_valid/s_last/s_ready   pixel stream handshake
//   wr_en/wr_addr/wr_data           RAM write port, one cycle after the beat
//   busy                a load is in progress
//   done                one-cycle pulse alongside the final write
//   err                 sticky framing error of the last frame
module frame_loader #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 2 + $clog2(IMG_W) + $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        slot,
  input  logic              abort,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t              state_reg, state_next;
  logic [1:0]          slot_reg;
  logic [XW-1:0]       x_reg;
  logic [YW-1:0]       y_reg;
  logic                wr_en_reg;
  logic [ADDR_W-1:0]   wr_addr_reg;
  logic [7:0]          wr_data_reg;
  logic                done_reg;
  logic                err_reg;

  logic                beat;
  logic                x_last;
  logic                at_final;
  logic                frame_end;

  // The state is a single flop, so ready/busy come straight from a register.
  assign s_ready = (state_reg == ST_RUN);
  assign busy    = (state_reg == ST_RUN);

  // Abort takes priority over a beat presented in the same cycle: the sender
  // treats abort as a flush, so that byte is dropped.
  assign beat     = s_valid && s_ready && !abort;
  assign x_last   = (x_reg == XW'(IMG_W - 1));
  assign at_final = x_last && (y_reg == YW'(IMG_H - 1));

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign done    = done_reg;
  assign err     = err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    frame_end  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // start wins over a simultaneous abort; abort alone does nothing here
        if (start) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (beat && (at_final || s_last)) begin
          state_next = ST_IDLE;
          frame_end  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_reg    <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      wr_en_reg <= beat;
      done_reg  <= frame_end;

      if (beat) begin
        wr_addr_reg <= ADDR_W'({slot_reg, y_reg, x_reg});
        wr_data_reg <= s_data;
        // The y wrap after the final beat is harmless: the frame ends there
        // and the next start reloads both counters.
        if (x_last) begin
          x_reg <= '0;
          y_reg <= y_reg + 1'b1;
        end else begin
          x_reg <= x_reg + 1'b1;
        end
      end

      if (state_reg == ST_IDLE && start) begin
        slot_reg <= slot;
        x_reg    <= '0;
        y_reg    <= '0;
        err_reg  <= 1'b0;
      end

      // Clean only when s_last coincides exactly with the final position;
      // early s_last (short frame) or missing s_last both flag an error.
      if (frame_end) begin
        err_reg <= !(at_final && s_last);
      end
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
module tb_frame_loader;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic              start;
  logic [1:0]        slot;
  logic              abort;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;
  logic              err;

  frame_loader #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .slot    (slot),
    .abort   (abort),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              done;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   run_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every RAM write pops one expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) run_cycles++;
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(wr_addr), 32'hFFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("write addr=%02h data=%02h done=%0b err=%0b", wr_addr, wr_data, done, err);
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", 32'(wr_data), 32'(e.data));
          chk("wr_done", 32'(done), 32'(e.done));
          chk("wr_err",  32'(err),  32'(e.err));
        end
      end else if (done) begin
        chk("done_without_write", 32'(done), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] s);
    start = 1'b1;
    slot  = s;
    tick();
    start = 1'b0;
    slot  = 2'd0;
  endtask

  // Presents one byte for one cycle; queues the expected write if the
  // byte will be accepted.
  task automatic beat(input logic [7:0] d, input logic l, input logic [ADDR_W-1:0] ea,
                      input logic ed, input logic ee, input logic ab);
    exp_t e;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    abort   = ab;
    if (s_ready && !ab) begin
      e.addr = ea; e.data = d; e.done = ed; e.err = ee;
      exp_q.push_back(e);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    abort   = 1'b0;
  endtask

  task automatic flush(input string name);
    tick();
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  int rc0;

  initial begin
    reset = 1'b1; start = 1'b0; slot = 2'd0; abort = 1'b0;
    s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
    #2;
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_busy",    32'(busy),    0);
    chk("rst_wr_en",   32'(wr_en),   0);
    chk("rst_done",    32'(done),    0);
    chk("rst_err",     32'(err),     0);
    #10 reset = 1'b0;
    tick();

    // Full frame, back-to-back, slot 2
    do_start(2'd2);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_ready", 32'(s_ready), 1);
    for (int i = 0; i < 8; i++)
      beat(8'(8'h10 + i), i == 7, 5'(5'h10 + i), i == 7, 1'b0, 1'b0);
    chk("t1_ready_fall", 32'(s_ready), 0);
    chk("t1_busy_fall", 32'(busy), 0);
    flush("t1_queue");
    chk("t1_done_pulse", 32'(done), 0);

    // Same frame with a one-cycle gap between beats
    rc0 = run_cycles;
    do_start(2'd2);
    for (int i = 0; i < 8; i++) begin
      beat(8'(8'h20 + i), i == 7, 5'(5'h10 + i), i == 7, 1'b0, 1'b0);
      if (i < 7) tick();
    end
    flush("t2_queue");
    chk("t2_run_cycles", 32'(run_cycles - rc0), 32'd15);

    // Short frame: s_last on beat 5, slot 0
    do_start(2'd0);
    for (int i = 0; i < 5; i++)
      beat(8'(8'h30 + i), i == 4, 5'(i), i == 4, i == 4, 1'b0);
    flush("t3_queue");
    chk("t3_err_sticky", 32'(err), 1);
    do_start(2'd1);
    chk("t3_err_clear", 32'(err), 0);

    // Abort with beat 3 (slot 1); a start pulse mid-run must be ignored
    beat(8'h40, 1'b0, 5'h08, 1'b0, 1'b0, 1'b0);
    start = 1'b1; slot = 2'd3;
    tick();
    start = 1'b0; slot = 2'd0;
    beat(8'h41, 1'b0, 5'h09, 1'b0, 1'b0, 1'b0);
    beat(8'h42, 1'b0, 5'h0A, 1'b0, 1'b0, 1'b1);
    chk("t5_busy_abort", 32'(busy), 0);
    chk("t5_ready_abort", 32'(s_ready), 0);
    chk("t5_no_done", 32'(done), 0);
    chk("t5_no_write", 32'(wr_en), 0);
    flush("t5_queue");
    chk("t5_err_kept", 32'(err), 0);

    // Missing s_last, slot 3
    do_start(2'd3);
    for (int i = 0; i < 8; i++)
      beat(8'(8'h50 + i), 1'b0, 5'(5'h18 + i), i == 7, i == 7, 1'b0);
    flush("t4_queue");
    chk("t4_err", 32'(err), 1);

    // start with abort in IDLE, then reset mid-frame
    abort = 1'b1;
    do_start(2'd2);
    abort = 1'b0;
    chk("t6_start_over_abort", 32'(busy), 1);
    for (int i = 0; i < 3; i++)
      beat(8'(8'h60 + i), 1'b0, 5'(5'h10 + i), 1'b0, 1'b0, 1'b0);
    beat(8'h63, 1'b0, 5'h13, 1'b0, 1'b0, 1'b0);
    chk("t6_wr_before_rst", 32'(wr_en), 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(s_ready), 0);
    chk("t6_rst_busy",  32'(busy),    0);
    chk("t6_rst_wr_en", 32'(wr_en),   0);
    exp_q.delete();
    #5 reset = 1'b0;
    tick();
    chk("t6_idle_after_rst", 32'(busy), 0);
    do_start(2'd2);
    for (int i = 0; i < 8; i++)
      beat(8'(8'h70 + i), i == 7, 5'(5'h10 + i), i == 7, 1'b0, 1'b0);
    flush("t6_queue");
    chk("t6_err", 32'(err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
